nn_layer_sequencer: RTL
=======================

Name: nn_layer_sequencer

Overview:
- Control FSM for the 10-neuron, 3-layer neural-network datapath: hidden layer 1, hidden layer 2, then the output layer.
- Drives the datapath's `state`, `start`, `hidden`, `ld1` and `ld2` inputs and waits on the per-neuron ready flags.
- Captures the classified result (`test_out`) and returns it through a valid/ack handshake.
- Includes a per-layer watchdog that aborts a layer that never completes.

Parameters:
- N_NEURONS, 10, number of neuron ready flags ANDed into layer-complete.
- CLASS_W, 8, width of the class input and the result.
- TMO_W, 16, watchdog counter width.
- TMO_CYCLES, 1024, maximum WAIT-state cycles per layer before error.

Ports:
- clk  in  1  clock; all flops rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- go  in  1  request to classify the currently presented test_data.
- go_ready  out  1  high in IDLE; a go is accepted when go && go_ready.
- neuron_ready  in  N_NEURONS  per-neuron ready from the datapath ANN instances.
- class_in  in  CLASS_W  datapath classifier output (test_out).
- nn_state  out  2  datapath layer select: 00 = L1, 01 = L2, 10 = output.
- nn_start  out  1  one-cycle start pulse to all neurons.
- nn_hidden  out  1  hidden-layer activation select.
- nn_ld1  out  1  load L1 result registers.
- nn_ld2  out  1  load L2 result registers.
- busy  out  1  high from go acceptance until return to IDLE.
- result  out  CLASS_W  captured class.
- result_valid  out  1  result available.
- result_ack  in  1  consumer acknowledge.
- error  out  1  sticky watchdog flag.
- cycle_count  out  TMO_W  go-to-result latency (optional feature).

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE.
  - nn_state=00; nn_start, nn_hidden, nn_ld1, nn_ld2, busy, result_valid, error = 0.
  - result=0, cycle_count=0, go_ready=1.
  - Reset mid-operation aborts immediately; no ld pulse or result is produced.
- States: IDLE, L1_GO, L1_WAIT, L1_LD, L2_GO, L2_WAIT, L2_LD, O_GO, O_WAIT, DONE, ERR.
- IDLE:
  - go_ready=1.
  - On go, move to L1_GO, clear error, and latch busy=1 at the next edge.
- x_GO: nn_start=1 for exactly one cycle, then move to x_WAIT.
- x_WAIT:
  - all_ready = &neuron_ready. It is ignored in the first WAIT cycle because ready is stale from the previous layer.
  - From the second WAIT cycle on, all_ready=1 advances the FSM: L1_WAIT→L1_LD, L2_WAIT→L2_LD, O_WAIT→DONE.
- L1_LD: nn_ld1=1 for one cycle, then L2_GO.
- L2_LD: nn_ld2=1 for one cycle, then O_GO.
- Outputs per layer:
  - nn_state = 00 in IDLE and L1_*; 01 in L2_*; 10 in O_*. It holds its value during LD/DONE.
  - nn_hidden=1 in L1_* and L2_*; otherwise 0.
- O_WAIT→DONE edge: result <= class_in, result_valid <= 1.
- DONE:
  - Hold result_valid and result stable until result_ack=1.
  - Then return to IDLE, with result_valid=0 and busy=0 at that edge.
  - If result_ack is already high on DONE entry, DONE lasts one cycle.
  - go is ignored in DONE.
- Watchdog:
  - Counter clears on each x_GO and increments in x_WAIT, saturating at its maximum.
  - When count == TMO_CYCLES-1 and all_ready=0, go to ERR.
  - all_ready and the timeout arriving in the same cycle: all_ready wins.
- ERR:
  - error=1, busy=0, no result.
  - Return to IDLE next cycle; error stays sticky until the next accepted go.
- go while busy: ignored, not queued.
- Minimum latency, go edge to result_valid: 3×(GO+2 WAIT) + 2 LD = 11 cycles.

Optional Feature:
- NN_CYCLE_COUNT_EN defined:
  - cycle_count clears on go acceptance and increments every busy cycle, saturating at all-ones.
  - It freezes when result_valid rises and holds until the next go.
- Not defined: cycle_count is tied to 0 and no counter logic is generated. The port is always present.

Test Plan:
- Reset mid-L2_WAIT (rst=0 for 1 cycle) → all control outputs 0 immediately, nn_state=00, go_ready=1, no nn_ld2 pulse.
- go=1 one cycle; neuron_ready=all-ones from the second WAIT cycle of each layer; class_in=8'h05 → exactly 3 nn_start pulses, then nn_ld1 and nn_ld2 each pulse once in order, nn_state sequence 00→01→10; result=8'h05 and result_valid at cycle 11; with NN_CYCLE_COUNT_EN, cycle_count=11.
- neuron_ready stuck all-ones through a GO → the first WAIT cycle does not advance; each layer still takes exactly 2 WAIT cycles.
- neuron_ready[7]=0 during L2 with TMO_CYCLES=16 → ERR after 16 L2_WAIT cycles; error=1, no nn_ld2, result_valid=0; the next go clears error.
- result_ack held low 20 cycles → result stable and valid, go=1 ignored, busy=1; ack=1 → IDLE next edge.
- Ready rises on exactly the timeout cycle → layer completes, error stays 0.

Source files
------------

// File: rtl/nn_layer_sequencer.sv
// Control FSM for the 3-layer NN datapath (L1, L2, output) with a per-layer watchdog; result at least 11 cycles after go.
// Result is held on valid/ack and go is refused until ack; NN_CYCLE_COUNT_EN adds the go-to-result latency counter.
module nn_layer_sequencer #(
    parameter int N_NEURONS  = 10,
    parameter int CLASS_W    = 8,
    parameter int TMO_W      = 16,
    parameter int TMO_CYCLES = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    output logic                 go_ready,
    input  logic [N_NEURONS-1:0] neuron_ready,
    input  logic [CLASS_W-1:0]   class_in,
    output logic [1:0]           nn_state,
    output logic                 nn_start,
    output logic                 nn_hidden,
    output logic                 nn_ld1,
    output logic                 nn_ld2,
    output logic                 busy,
    output logic [CLASS_W-1:0]   result,
    output logic                 result_valid,
    input  logic                 result_ack,
    output logic                 error,
    output logic [TMO_W-1:0]     cycle_count
);

    typedef enum logic [3:0] {
        IDLE, L1_GO, L1_WAIT, L1_LD, L2_GO, L2_WAIT, L2_LD, O_GO, O_WAIT, DONE, ERR
    } state_t;

    localparam logic [1:0]       SEL_L1   = 2'b00;
    localparam logic [1:0]       SEL_L2   = 2'b01;
    localparam logic [1:0]       SEL_OUT  = 2'b10;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYCLES - 1);

    state_t           state, state_n;
    logic [TMO_W-1:0] wd_cnt;
    logic             all_ready;
    logic             first_wait;
    logic             wait_done;
    logic             wait_tmo;
    logic             in_go;
    logic             in_wait;
    logic             accept;

    assign all_ready  = &neuron_ready;
    // The counter is zero only in the first WAIT cycle, where ready still reflects the previous layer.
    assign first_wait = (wd_cnt == '0);
    assign wait_done  = all_ready && !first_wait;
    assign wait_tmo   = (wd_cnt == TMO_LAST) && !wait_done;

    assign in_go    = (state == L1_GO)   || (state == L2_GO)   || (state == O_GO);
    assign in_wait  = (state == L1_WAIT) || (state == L2_WAIT) || (state == O_WAIT);
    assign go_ready = (state == IDLE);
    assign accept   = go && go_ready;
    assign busy     = (state != IDLE) && (state != ERR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n   = state;
        nn_start  = 1'b0;
        nn_hidden = 1'b0;
        nn_ld1    = 1'b0;
        nn_ld2    = 1'b0;
        case (state)
            IDLE: begin
                if (go) state_n = L1_GO;
            end
            L1_GO: begin
                nn_start  = 1'b1;
                nn_hidden = 1'b1;
                state_n   = L1_WAIT;
            end
            L1_WAIT: begin
                nn_hidden = 1'b1;
                if (wait_done)     state_n = L1_LD;
                else if (wait_tmo) state_n = ERR;
            end
            L1_LD: begin
                nn_hidden = 1'b1;
                nn_ld1    = 1'b1;
                state_n   = L2_GO;
            end
            L2_GO: begin
                nn_start  = 1'b1;
                nn_hidden = 1'b1;
                state_n   = L2_WAIT;
            end
            L2_WAIT: begin
                nn_hidden = 1'b1;
                if (wait_done)     state_n = L2_LD;
                else if (wait_tmo) state_n = ERR;
            end
            L2_LD: begin
                nn_hidden = 1'b1;
                nn_ld2    = 1'b1;
                state_n   = O_GO;
            end
            O_GO: begin
                nn_start = 1'b1;
                state_n  = O_WAIT;
            end
            O_WAIT: begin
                if (wait_done)     state_n = DONE;
                else if (wait_tmo) state_n = ERR;
            end
            DONE: begin
                if (result_ack) state_n = IDLE;
            end
            ERR: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Layer select follows the state being entered and holds through LD, DONE and ERR.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            nn_state <= SEL_L1;
        end else begin
            case (state_n)
                IDLE, L1_GO: nn_state <= SEL_L1;
                L2_GO:       nn_state <= SEL_L2;
                O_GO:        nn_state <= SEL_OUT;
                default:     nn_state <= nn_state;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wd_cnt <= '0;
        end else if (in_go) begin
            wd_cnt <= '0;
        end else if (in_wait && (wd_cnt != '1)) begin
            wd_cnt <= wd_cnt + TMO_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            result       <= '0;
            result_valid <= 1'b0;
        end else if ((state == O_WAIT) && (state_n == DONE)) begin
            result       <= class_in;
            result_valid <= 1'b1;
        end else if ((state == DONE) && result_ack) begin
            result_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            error <= 1'b0;
        end else if (accept) begin
            error <= 1'b0;
        end else if (state_n == ERR) begin
            error <= 1'b1;
        end
    end

`ifdef NN_CYCLE_COUNT_EN
    // Counts every busy cycle up to and including the one that raises result_valid, then freezes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_count <= '0;
        end else if (accept) begin
            cycle_count <= '0;
        end else if (busy && !result_valid && (cycle_count != '1)) begin
            cycle_count <= cycle_count + TMO_W'(1);
        end
    end
`else
    assign cycle_count = '0;
`endif

endmodule
